multi_key_input: RTL and testbench

- Parametrised N-channel push-button/switch input unit. Replaces the per-button debounce instances at CPU top.
- Per channel: synchronises, debounces and detects press/release edges. Latches sticky event flags.
- Exposes everything to the CPU as a small memory-mapped IO register window read combinationally by MemOrIO, plus an interrupt-style summary line.

---
 rtl/key_io_pkg.sv | 22 ++
 rtl/key_debounce_ch.sv | 84 ++++++++
 rtl/multi_key_input.sv | 104 ++++++++++
 tb/tb_multi_key_input.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_io_pkg.sv
// Shared definitions for the multi-channel key input unit: register map,
// debounce state encoding and the MemOrIO base address of the window.
package key_io_pkg;

  localparam logic [1:0] OFS_LEVEL = 2'd0;
  localparam logic [1:0] OFS_PRESS = 2'd1;
  localparam logic [1:0] OFS_REL   = 2'd2;
  localparam logic [1:0] OFS_MASK  = 2'd3;

  localparam logic [31:0] KEY_IO_BASE = 32'hFFFF_FC70;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } db_state_e;

  // Event-flag update: clears apply first so a same-cycle set is never lost.
  function automatic logic evt_next(input logic cur, input logic clr, input logic set);
    return (cur & ~clr) | set;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One input channel: optional inversion, two-flop synchroniser, stability
// counter FSM and accepted-edge outputs.
module key_debounce_ch
  import key_io_pkg::*;
#(
  parameter int DB_CYCLES  = 1000000,
  parameter int CNT_W      = $clog2(DB_CYCLES + 1),
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_level,
  output logic o_press_pulse,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  db_state_e        r_state;

  logic w_key;
  logic w_accept;

  assign w_key = ACTIVE_LOW ? ~i_key : i_key;

  // Edge events are decoded from current state so the top can latch them on
  // the same edge that updates the stable level.
  assign w_accept = (r_state == ST_COUNT) && (r_sync2 != r_stable) && (r_cnt == CNT_LAST);
  assign o_rise   = w_accept & r_sync2;
  assign o_fall   = w_accept & ~r_sync2;

  assign o_level       = r_stable;
  assign o_press_pulse = r_press;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
      r_cnt    <= '0;
      r_state  <= ST_STABLE;
    end else begin
      r_sync1 <= w_key;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      case (r_state)
        ST_STABLE: begin
          if (r_sync2 != r_stable) begin
            r_state <= ST_COUNT;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        ST_COUNT: begin
          if (r_sync2 == r_stable) begin
            r_cnt   <= '0;
            r_state <= ST_STABLE;
          end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync2;
            r_press  <= r_sync2;
            r_cnt    <= '0;
            r_state  <= ST_STABLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_STABLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_key_input.sv
// N-channel debounced key input with sticky press/release flags, an IRQ mask
// and a four-word MemOrIO register window.
module multi_key_input
  import key_io_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int DB_CYCLES   = 1000000,
  parameter int CNT_W       = $clog2(DB_CYCLES + 1),
  parameter int ACTIVE_LOW  = 0,
  parameter int CLR_ON_READ = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] key_in,
  input  logic            io_rd,
  input  logic            io_wr,
  input  logic [1:0]      io_addr,
  input  logic [31:0]     io_wdata,
  output logic [31:0]     io_rdata,
  output logic [N_CH-1:0] key_level,
  output logic [N_CH-1:0] press_pulse,
  output logic            irq
);

  logic [N_CH-1:0] w_level;
  logic [N_CH-1:0] w_pulse;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_fall;
  logic [N_CH-1:0] w_clr_press;
  logic [N_CH-1:0] w_clr_rel;
  logic [31:0]     w_rdata;
  logic            w_wr_press;
  logic            w_wr_rel;
  logic            w_rd_clr_press;
  logic            w_rd_clr_rel;
  logic            w_unused;

  logic [N_CH-1:0] r_evt_press;
  logic [N_CH-1:0] r_evt_rel;
  logic [N_CH-1:0] r_mask;
  logic            r_irq;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES  (DB_CYCLES),
      .CNT_W      (CNT_W),
      .ACTIVE_LOW (ACTIVE_LOW != 0)
    ) u_ch (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_key         (key_in[g]),
      .o_level       (w_level[g]),
      .o_press_pulse (w_pulse[g]),
      .o_rise        (w_rise[g]),
      .o_fall        (w_fall[g])
    );
  end

  assign w_wr_press     = io_wr && (io_addr == OFS_PRESS);
  assign w_wr_rel       = io_wr && (io_addr == OFS_REL);
  assign w_rd_clr_press = (CLR_ON_READ != 0) && io_rd && (io_addr == OFS_PRESS);
  assign w_rd_clr_rel   = (CLR_ON_READ != 0) && io_rd && (io_addr == OFS_REL);

  assign w_clr_press = ({N_CH{w_wr_press}} & io_wdata[N_CH-1:0]) | {N_CH{w_rd_clr_press}};
  assign w_clr_rel   = ({N_CH{w_wr_rel}}   & io_wdata[N_CH-1:0]) | {N_CH{w_rd_clr_rel}};

  assign w_unused = ^io_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt_press <= '0;
      r_evt_rel   <= '0;
      r_mask      <= '0;
      r_irq       <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        r_evt_press[i] <= evt_next(r_evt_press[i], w_clr_press[i], w_rise[i]);
        r_evt_rel[i]   <= evt_next(r_evt_rel[i], w_clr_rel[i], w_fall[i]);
      end
      if (io_wr && (io_addr == OFS_MASK)) begin
        r_mask <= io_wdata[N_CH-1:0];
      end
      r_irq <= |((r_evt_press | r_evt_rel) & r_mask);
    end
  end

  // Read data shows pre-clear flag values in the cycle of a clearing read.
  always_comb begin
    w_rdata = 32'd0;
    case (io_addr)
      OFS_LEVEL: w_rdata[N_CH-1:0] = w_level;
      OFS_PRESS: w_rdata[N_CH-1:0] = r_evt_press;
      OFS_REL:   w_rdata[N_CH-1:0] = r_evt_rel;
      OFS_MASK:  w_rdata[N_CH-1:0] = r_mask;
      default:   w_rdata = 32'd0;
    endcase
  end

  assign io_rdata    = w_rdata;
  assign key_level   = w_level;
  assign press_pulse = w_pulse;
  assign irq         = r_irq;

endmodule

// File: tb/tb_multi_key_input.sv
// Directed bench for multi_key_input: three configurations share one clock,
// expected values go through a scoreboard queue.
module tb_multi_key_input;

  logic clk;
  logic rst;

  logic [7:0]  a_key, a_level, a_pulse;
  logic        a_rd, a_wr, a_irq;
  logic [1:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;

  logic [7:0]  b_key, b_level, b_pulse;
  logic        b_rd, b_wr, b_irq;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;

  logic [4:0]  c_key, c_level, c_pulse;
  logic        c_rd, c_wr, c_irq;
  logic [1:0]  c_addr;
  logic [31:0] c_wdata, c_rdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  int pulse_cnt;
  int pulse_at;

  multi_key_input #(.N_CH(8), .DB_CYCLES(4), .ACTIVE_LOW(0), .CLR_ON_READ(0)) u_a (
    .clk(clk), .rst(rst), .key_in(a_key), .io_rd(a_rd), .io_wr(a_wr), .io_addr(a_addr),
    .io_wdata(a_wdata), .io_rdata(a_rdata), .key_level(a_level), .press_pulse(a_pulse), .irq(a_irq)
  );

  multi_key_input #(.N_CH(8), .DB_CYCLES(4), .ACTIVE_LOW(0), .CLR_ON_READ(1)) u_b (
    .clk(clk), .rst(rst), .key_in(b_key), .io_rd(b_rd), .io_wr(b_wr), .io_addr(b_addr),
    .io_wdata(b_wdata), .io_rdata(b_rdata), .key_level(b_level), .press_pulse(b_pulse), .irq(b_irq)
  );

  multi_key_input #(.N_CH(5), .DB_CYCLES(4), .ACTIVE_LOW(1), .CLR_ON_READ(0)) u_c (
    .clk(clk), .rst(rst), .key_in(c_key), .io_rd(c_rd), .io_wr(c_wr), .io_addr(c_addr),
    .io_wdata(c_wdata), .io_rdata(c_rdata), .key_level(c_level), .press_pulse(c_pulse), .irq(c_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<none queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic a_write(input logic [1:0] addr, input logic [31:0] data);
    a_wr = 1'b1; a_addr = addr; a_wdata = data;
    tick();
    a_wr = 1'b0; a_wdata = 32'd0;
  endtask

  task automatic a_sel(input logic [1:0] addr);
    a_addr = addr;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_key = 8'h00; a_rd = 1'b0; a_wr = 1'b0; a_addr = 2'd0; a_wdata = 32'd0;
    b_key = 8'h00; b_rd = 1'b0; b_wr = 1'b0; b_addr = 2'd0; b_wdata = 32'd0;
    c_key = 5'h1F; c_rd = 1'b0; c_wr = 1'b0; c_addr = 2'd0; c_wdata = 32'd0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    expect_val(32'h0); chk("rst_level", {24'd0, a_level});
    expect_val(32'h0); chk("rst_pulse", {24'd0, a_pulse});
    expect_val(32'h0); chk("rst_irq", {31'd0, a_irq});
    expect_val(32'h0); chk("rst_rdata", a_rdata);
    expect_val(32'h0); chk("c_rst_level_inv", c_rdata);

    // single press on ch0: level and pulse at cycle 6
    a_key = 8'h01;
    repeat (5) tick();
    expect_val(32'h0); chk("press_c5_level", {24'd0, a_level});
    expect_val(32'h0); chk("press_c5_pulse", {24'd0, a_pulse});
    tick();
    expect_val(32'h1); chk("press_c6_level", {24'd0, a_level});
    expect_val(32'h1); chk("press_c6_pulse", {24'd0, a_pulse});
    a_sel(2'd1);
    expect_val(32'h1); chk("press_evt", a_rdata);
    tick();
    expect_val(32'h0); chk("press_c7_pulse", {24'd0, a_pulse});

    // bounce on ch1: 3 high, 1 low, then steady high
    pulse_cnt = 0; pulse_at = -1;
    a_key[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (a_pulse[1]) pulse_cnt++;
    end
    a_key[1] = 1'b0;
    tick();
    if (a_pulse[1]) pulse_cnt++;
    a_key[1] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (a_pulse[1]) begin
        pulse_cnt++;
        if (pulse_at < 0) pulse_at = i;
      end
    end
    expect_val(32'd1); chk("bounce_pulse_count", pulse_cnt);
    expect_val(32'd6); chk("bounce_pulse_cycle", pulse_at);

    // W1C
    a_write(2'd1, 32'h2);
    a_key = 8'h07;
    repeat (6) tick();
    a_sel(2'd1);
    expect_val(32'h5); chk("w1c_before", a_rdata);
    a_write(2'd1, 32'h1);
    a_sel(2'd1);
    expect_val(32'h4); chk("w1c_after", a_rdata);

    // same-cycle press on ch0 and clear of bit0: set wins
    a_key = 8'h06;
    repeat (7) tick();
    a_key = 8'h07;
    repeat (5) tick();
    a_wr = 1'b1; a_addr = 2'd1; a_wdata = 32'h1;
    tick();
    expect_val(32'h1); chk("setclr_pulse", {24'd0, a_pulse});
    a_wr = 1'b0; a_wdata = 32'd0;
    a_sel(2'd1);
    expect_val(32'h5); chk("setclr_press", a_rdata);
    a_sel(2'd2);
    expect_val(32'h1); chk("setclr_rel", a_rdata);

    // upper mask bits are not stored; LEVEL is read-only
    a_write(2'd3, 32'hFFFF_FF00);
    a_write(2'd0, 32'hFFFF_FFFF);
    a_sel(2'd3);
    expect_val(32'h0); chk("mask_upper_ignored", a_rdata);
    a_sel(2'd0);
    expect_val(32'h7); chk("level_ro", a_rdata);

    // IRQ masking
    a_key = 8'h05;
    repeat (7) tick();
    a_write(2'd1, 32'hFF);
    a_write(2'd2, 32'hFF);
    a_write(2'd3, 32'h02);
    tick();
    expect_val(32'h0); chk("irq_cleared", {31'd0, a_irq});
    a_key = 8'h04;
    repeat (7) tick();
    a_key = 8'h05;
    repeat (7) tick();
    a_sel(2'd1);
    expect_val(32'h1); chk("irq_ch0_flag", a_rdata);
    expect_val(32'h0); chk("irq_ch0_masked", {31'd0, a_irq});
    a_key = 8'h07;
    repeat (6) tick();
    expect_val(32'h0); chk("irq_same_cycle", {31'd0, a_irq});
    tick();
    expect_val(32'h1); chk("irq_ch1", {31'd0, a_irq});
    a_wr = 1'b1; a_addr = 2'd1; a_wdata = 32'h2;
    tick();
    a_wr = 1'b0; a_wdata = 32'd0;
    expect_val(32'h1); chk("irq_clr_edge", {31'd0, a_irq});
    tick();
    expect_val(32'h0); chk("irq_after_clr", {31'd0, a_irq});

    // clear-on-read instance
    b_key = 8'h08;
    repeat (7) tick();
    b_key = 8'h00;
    repeat (7) tick();
    b_addr = 2'd2; b_rd = 1'b1;
    #1;
    expect_val(32'h8); chk("cor_first", b_rdata);
    tick();
    expect_val(32'h0); chk("cor_second", b_rdata);
    b_rd = 1'b0; b_addr = 2'd1;
    #1;
    expect_val(32'h8); chk("cor_press_kept", b_rdata);

    // active-low instance
    c_key = 5'h0F;
    repeat (5) tick();
    expect_val(32'h0); chk("al_c5", c_rdata);
    tick();
    expect_val(32'h10); chk("al_c6", c_rdata);
    c_key = 5'h1F;
    repeat (7) tick();
    expect_val(32'h0); chk("al_release", c_rdata);
    c_key = 5'h0F;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    expect_val(32'h0); chk("al_rst_c5", c_rdata);
    tick();
    expect_val(32'h10); chk("al_rst_c6", c_rdata);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
